memory_arbiter: RTL and testbench

//  Shares the single RAM port between the datapath's instruction-fetch and data requests.

---
 rtl/memory_arbiter.sv | 140 ++++++++++++++
 tb/tb_memory_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// ============================================================================
// Module   : memory_arbiter
// Brief    : Single-port RAM arbiter between instruction fetch and data access.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_arbiter #(
    parameter int MAX_DSTREAK = 4,
    parameter int CNT_W       = 3
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        memerr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_INSTR = 2'd2
    } state_t;

    localparam logic [1:0]       c_RAM_ACCESS = 2'b10;
    localparam logic [1:0]       c_RAM_ERROR  = 2'b11;
    localparam logic [CNT_W-1:0] c_MAX_STREAK = CNT_W'(MAX_DSTREAK);

    state_t           r_state;
    logic [CNT_W-1:0] r_streak;
    logic             r_memerr;

    logic w_dreq;
    logic w_access;
    logic w_error;
    logic w_starve;

    assign w_dreq   = dREN | dWEN;
    assign w_access = (ramstate == c_RAM_ACCESS);
    assign w_error  = (ramstate == c_RAM_ERROR);
    // Fetch has waited through a full data streak and must win this round.
    assign w_starve = iREN & (r_streak == c_MAX_STREAK);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= ST_IDLE;
            r_streak <= '0;
            r_memerr <= 1'b0;
        end else begin
            r_memerr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!iREN)
                        r_streak <= '0;
                    if (w_dreq && !w_starve)
                        r_state <= ST_DATA;
                    else if (iREN)
                        r_state <= ST_INSTR;
                end
                ST_DATA: begin
                    if (!w_dreq) begin
                        r_state <= ST_IDLE;
                    end else if (w_access) begin
                        r_state <= ST_IDLE;
                        if (iREN && (r_streak != c_MAX_STREAK))
                            r_streak <= r_streak + 1'b1;
                    end else if (w_error) begin
                        r_state  <= ST_IDLE;
                        r_memerr <= 1'b1;
                    end
                end
                ST_INSTR: begin
                    if (!iREN) begin
                        r_state <= ST_IDLE;
                    end else if (w_access) begin
                        r_state  <= ST_IDLE;
                        r_streak <= '0;
                    end else if (w_error) begin
                        r_state  <= ST_IDLE;
                        r_memerr <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign memerr = r_memerr;

    // RAM-side and requester-side views follow the registered grant; a
    // withdrawn request drops its strobe and never reports completion.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        iload    = '0;
        dwait    = 1'b1;
        dload    = '0;
        case (r_state)
            ST_DATA: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (w_dreq && w_access) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            ST_INSTR: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (iREN && w_access) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
// ============================================================================
// Module   : tb_memory_arbiter
// Brief    : Directed scoreboard bench for memory_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, memerr;
    logic [31:0] iload, dload, ramaddr, ramstore;

    localparam logic [1:0] c_FREE   = 2'b00;
    localparam logic [1:0] c_BUSY   = 2'b01;
    localparam logic [1:0] c_ACCESS = 2'b10;
    localparam logic [1:0] c_ERROR  = 2'b11;

    localparam int c_S_RAMREN = 0, c_S_RAMWEN = 1, c_S_RAMADDR = 2, c_S_RAMSTORE = 3,
                   c_S_IWAIT = 4, c_S_ILOAD = 5, c_S_DWAIT = 6, c_S_DLOAD = 7,
                   c_S_MEMERR = 8;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    memory_arbiter #(.MAX_DSTREAK(4), .CNT_W(3)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] observe(int sig);
        case (sig)
            c_S_RAMREN:   return {31'd0, ramREN};
            c_S_RAMWEN:   return {31'd0, ramWEN};
            c_S_RAMADDR:  return ramaddr;
            c_S_RAMSTORE: return ramstore;
            c_S_IWAIT:    return {31'd0, iwait};
            c_S_ILOAD:    return iload;
            c_S_DWAIT:    return {31'd0, dwait};
            c_S_DLOAD:    return dload;
            default:      return {31'd0, memerr};
        endcase
    endfunction

    task automatic expect_v(input string tag, input int sig, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = observe(e.sig);
            n_tests++;
            assert (o === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
            end
        end
    endtask

    // Compare mid-cycle, then advance to just after the next rising edge.
    task automatic step();
        @(negedge CLK);
        drain();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = c_FREE;

        // Reset with both requests present
        expect_v("rst_ramREN", c_S_RAMREN, 0);
        expect_v("rst_ramWEN", c_S_RAMWEN, 0);
        expect_v("rst_iwait",  c_S_IWAIT,  1);
        expect_v("rst_dwait",  c_S_DWAIT,  1);
        expect_v("rst_memerr", c_S_MEMERR, 0);
        expect_v("rst_addr",   c_S_RAMADDR, 0);
        step();
        iREN = 1'b0; dREN = 1'b0;
        step();
        nRST = 1'b1;
        step();

        // Fetch: grant cycle, BUSY x2, ACCESS
        iREN = 1'b1; iaddr = 32'h40;
        expect_v("f_idle_ren", c_S_RAMREN, 0);
        expect_v("f_idle_iw",  c_S_IWAIT,  1);
        step();
        for (int k = 0; k < 2; k++) begin
            ramstate = c_BUSY;
            expect_v("f_busy_addr", c_S_RAMADDR, 32'h40);
            expect_v("f_busy_ren",  c_S_RAMREN,  1);
            expect_v("f_busy_iw",   c_S_IWAIT,   1);
            expect_v("f_busy_il",   c_S_ILOAD,   0);
            step();
        end
        ramstate = c_ACCESS; ramload = 32'h8C220004;
        expect_v("f_acc_addr", c_S_RAMADDR, 32'h40);
        expect_v("f_acc_iw",   c_S_IWAIT,   0);
        expect_v("f_acc_il",   c_S_ILOAD,   32'h8C220004);
        step();
        iREN = 1'b0; ramstate = c_FREE;
        expect_v("f_post_ren",  c_S_RAMREN,  0);
        expect_v("f_post_addr", c_S_RAMADDR, 0);
        step();

        // Priority: data write beats simultaneous fetch
        iREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        expect_v("p_idle_wen", c_S_RAMWEN, 0);
        step();
        ramstate = c_ACCESS;
        expect_v("p_d_wen",   c_S_RAMWEN,   1);
        expect_v("p_d_ren",   c_S_RAMREN,   0);
        expect_v("p_d_addr",  c_S_RAMADDR,  32'h100);
        expect_v("p_d_store", c_S_RAMSTORE, 32'hDEADBEEF);
        expect_v("p_d_dw",    c_S_DWAIT,    0);
        expect_v("p_d_iw",    c_S_IWAIT,    1);
        step();
        dWEN = 1'b0; ramstate = c_FREE;
        expect_v("p_idle2_ren", c_S_RAMREN, 0);
        step();
        ramstate = c_ACCESS; ramload = 32'h12345678;
        expect_v("p_i_addr", c_S_RAMADDR, 32'h40);
        expect_v("p_i_iw",   c_S_IWAIT,   0);
        expect_v("p_i_il",   c_S_ILOAD,   32'h12345678);
        step();

        // Starvation: four data grants then fetch is forced
        dREN = 1'b1; daddr = 32'h200; ramstate = c_FREE;
        expect_v("s_idle_ren", c_S_RAMREN, 0);
        expect_v("s_idle_dw",  c_S_DWAIT,  1);
        step();
        for (int k = 0; k < 4; k++) begin
            ramstate = c_ACCESS; ramload = 32'h1000 + k;
            expect_v("s_d_addr", c_S_RAMADDR, 32'h200);
            expect_v("s_d_dw",   c_S_DWAIT,   0);
            expect_v("s_d_dl",   c_S_DLOAD,   32'h1000 + k);
            expect_v("s_d_iw",   c_S_IWAIT,   1);
            step();
            ramstate = c_FREE;
            expect_v("s_gap_ren", c_S_RAMREN, 0);
            step();
        end
        ramstate = c_ACCESS; ramload = 32'h2000;
        expect_v("s_force_addr", c_S_RAMADDR, 32'h40);
        expect_v("s_force_iw",   c_S_IWAIT,   0);
        expect_v("s_force_il",   c_S_ILOAD,   32'h2000);
        expect_v("s_force_dw",   c_S_DWAIT,   1);
        step();
        ramstate = c_FREE;
        step();
        ramstate = c_ACCESS; ramload = 32'h3000;
        expect_v("s_after_addr", c_S_RAMADDR, 32'h200);
        expect_v("s_after_dw",   c_S_DWAIT,   0);
        step();
        iREN = 1'b0; dREN = 1'b0; ramstate = c_FREE;
        step();

        // Error on a data read, then re-grant
        dREN = 1'b1; daddr = 32'h300;
        step();
        ramstate = c_ERROR; ramload = 32'hFFFF0000;
        expect_v("e_ren",    c_S_RAMREN, 1);
        expect_v("e_dw",     c_S_DWAIT,  1);
        expect_v("e_dl",     c_S_DLOAD,  0);
        expect_v("e_me_pre", c_S_MEMERR, 0);
        step();
        ramstate = c_FREE;
        expect_v("e_me_pulse", c_S_MEMERR, 1);
        expect_v("e_idle_ren", c_S_RAMREN, 0);
        expect_v("e_idle_dw",  c_S_DWAIT,  1);
        step();
        ramstate = c_BUSY;
        expect_v("e_me_post", c_S_MEMERR,  0);
        expect_v("e_regrant", c_S_RAMREN,  1);
        expect_v("e_re_addr", c_S_RAMADDR, 32'h300);
        step();

        // Withdraw while BUSY
        dREN = 1'b0;
        expect_v("w_drop_ren", c_S_RAMREN, 0);
        expect_v("w_drop_dw",  c_S_DWAIT,  1);
        step();
        dREN = 1'b1;
        expect_v("w_idle_ren", c_S_RAMREN, 0);
        expect_v("w_idle_me",  c_S_MEMERR, 0);
        step();
        dREN = 1'b0; iREN = 1'b1; iaddr = 32'h80;
        expect_v("w_drop2_ren", c_S_RAMREN, 0);
        step();
        expect_v("w_idle2_ren", c_S_RAMREN, 0);
        step();
        expect_v("r_i_ren",  c_S_RAMREN,  1);
        expect_v("r_i_addr", c_S_RAMADDR, 32'h80);
        step();

        // Asynchronous reset mid-fetch
        nRST = 1'b0;
        #1;
        expect_v("r_async_ren",  c_S_RAMREN,  0);
        expect_v("r_async_addr", c_S_RAMADDR, 0);
        expect_v("r_async_iw",   c_S_IWAIT,   1);
        drain();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        expect_v("r_idle_ren", c_S_RAMREN, 0);
        step();
        ramstate = c_ACCESS; ramload = 32'hCAFEF00D;
        expect_v("r_i2_iw", c_S_IWAIT, 0);
        expect_v("r_i2_il", c_S_ILOAD, 32'hCAFEF00D);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
